// File: rtl/ow_pkg.sv
// Shared types and timing constants for the 1-Wire master.
package ow_pkg;

    localparam int unsigned CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_LOW   = 3'd1,
        RST_HIGH  = 3'd2,
        SLOT_LOW  = 3'd3,
        SLOT_HIGH = 3'd4,
        SLOT_REC  = 3'd5,
        FIN       = 3'd6
    } ow_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] rstl;
        logic [CNT_W-1:0] msp;
        logic [CNT_W-1:0] rsth;
        logic [CNT_W-1:0] slot;
        logic [CNT_W-1:0] low1;
        logic [CNT_W-1:0] msr;
        logic [CNT_W-1:0] rec;
    } ow_timing_t;

    localparam int unsigned STD_RSTL = 480;
    localparam int unsigned STD_MSP  = 70;
    localparam int unsigned STD_RSTH = 480;
    localparam int unsigned STD_SLOT = 60;
    localparam int unsigned STD_LOW1 = 6;
    localparam int unsigned STD_MSR  = 15;
    localparam int unsigned STD_REC  = 5;

    localparam int unsigned OD_RSTL = 48;
    localparam int unsigned OD_MSP  = 8;
    localparam int unsigned OD_RSTH = 48;
    localparam int unsigned OD_SLOT = 8;
    localparam int unsigned OD_LOW1 = 1;
    localparam int unsigned OD_MSR  = 2;
    localparam int unsigned OD_REC  = 2;

    function automatic ow_timing_t make_timing(
        input int unsigned rstl, input int unsigned msp, input int unsigned rsth,
        input int unsigned slot, input int unsigned low1, input int unsigned msr,
        input int unsigned rec);
        ow_timing_t t;
        t.rstl = CNT_W'(rstl);
        t.msp  = CNT_W'(msp);
        t.rsth = CNT_W'(rsth);
        t.slot = CNT_W'(slot);
        t.low1 = CNT_W'(low1);
        t.msr  = CNT_W'(msr);
        t.rec  = CNT_W'(rec);
        return t;
    endfunction

    localparam ow_timing_t OD_TIMING = make_timing(OD_RSTL, OD_MSP, OD_RSTH,
                                                   OD_SLOT, OD_LOW1, OD_MSR, OD_REC);

endpackage

// File: rtl/ow_tick_gen.sv
// 1 us tick prescaler; reload restarts the count so the first tick lands
// exactly CLK_DIV cycles after the reload cycle.
module ow_tick_gen #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    localparam logic [7:0] RELOAD_VAL = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    // Down-counter with registered tick raised for the cycle where cnt is 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 8'd0;
            tick <= 1'b0;
        end else if (reload) begin
            cnt  <= RELOAD_VAL;
            tick <= 1'b0;
        end else if (cnt == 8'd0) begin
            cnt  <= RELOAD_VAL;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt - 8'd1;
            tick <= (cnt == 8'd1);
        end
    end

endmodule

// File: rtl/ow_master.sv
// 1-Wire bus master: reset/presence sequence and LSB-first byte slots.
// Optional overdrive timings are enabled with the OW_OVERDRIVE_EN macro.
module ow_master
    import ow_pkg::*;
#(
    parameter int unsigned CLK_DIV = 10,
    parameter int unsigned T_RSTL  = STD_RSTL,
    parameter int unsigned T_MSP   = STD_MSP,
    parameter int unsigned T_RSTH  = STD_RSTH,
    parameter int unsigned T_SLOT  = STD_SLOT,
    parameter int unsigned T_LOW1  = STD_LOW1,
    parameter int unsigned T_MSR   = STD_MSR,
    parameter int unsigned T_REC   = STD_REC
) (
    input  logic       CLK,
    input  logic       MR,
    input  logic       CMD_RST,
    input  logic       CMD_BYTE,
    input  logic [7:0] TX_DATA,
`ifdef OW_OVERDRIVE_EN
    input  logic       OD,
`endif
    input  logic       IO_IN,
    output logic       IO_PD,
    output logic       BUSY,
    output logic       DONE,
    output logic       PRESENCE,
    output logic [7:0] RX_DATA
);

    localparam ow_timing_t STD_TIMING = make_timing(T_RSTL, T_MSP, T_RSTH,
                                                    T_SLOT, T_LOW1, T_MSR, T_REC);

    ow_state_t        state;
    logic             io_meta;
    logic             io_s;
    logic [CNT_W-1:0] us_cnt;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] us_nxt;
    logic [CNT_W-1:0] slot_nxt;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic [2:0]       bit_cnt;
    logic             accept;
    logic             tick;
    logic             sample_now;
    ow_timing_t       tim;

    assign accept   = (state == IDLE) && (CMD_RST || CMD_BYTE);
    assign us_nxt   = us_cnt + 10'd1;
    assign slot_nxt = slot_cnt + 10'd1;
    assign sample_now = tick && (slot_nxt == tim.msr);

    ow_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (CLK),
        .rst    (MR),
        .reload (accept),
        .tick   (tick)
    );

`ifdef OW_OVERDRIVE_EN
    logic od_sel;

    // Overdrive selection captured with the command
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            od_sel <= 1'b0;
        end else if (accept) begin
            od_sel <= OD;
        end else begin
            od_sel <= od_sel;
        end
    end

    // Timing set in force for the running sequence
    always_comb begin
        tim = STD_TIMING;
        if (od_sel) begin
            tim = OD_TIMING;
        end else begin
            tim = STD_TIMING;
        end
    end
`else
    assign tim = STD_TIMING;
`endif

    // Two-flop synchronizer on the raw line; idles high like the pulled-up bus
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            io_meta <= 1'b1;
            io_s    <= 1'b1;
        end else begin
            io_meta <= IO_IN;
            io_s    <= io_meta;
        end
    end

    // Sequencer; all bus and status outputs are registered here
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            state    <= IDLE;
            IO_PD    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PRESENCE <= 1'b0;
            RX_DATA  <= 8'h00;
            us_cnt   <= 10'd0;
            slot_cnt <= 10'd0;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            bit_cnt  <= 3'd0;
        end else begin
            DONE <= 1'b0;
            if (tick) begin
                us_cnt   <= us_nxt;
                slot_cnt <= slot_nxt;
            end
            case (state)
                IDLE: begin
                    us_cnt   <= 10'd0;
                    slot_cnt <= 10'd0;
                    if (CMD_RST) begin
                        state <= RST_LOW;
                        IO_PD <= 1'b1;
                        BUSY  <= 1'b1;
                    end else if (CMD_BYTE) begin
                        state   <= SLOT_LOW;
                        tx_sh   <= TX_DATA;
                        rx_sh   <= 8'h00;
                        bit_cnt <= 3'd0;
                        IO_PD   <= 1'b1;
                        BUSY    <= 1'b1;
                    end
                end
                RST_LOW: begin
                    if (tick && (us_nxt == tim.rstl)) begin
                        state  <= RST_HIGH;
                        IO_PD  <= 1'b0;
                        us_cnt <= 10'd0;
                    end
                end
                RST_HIGH: begin
                    if (tick && (us_nxt == tim.msp)) begin
                        PRESENCE <= ~io_s;
                    end
                    if (tick && (us_nxt == tim.rsth)) begin
                        state  <= FIN;
                        us_cnt <= 10'd0;
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                    end
                end
                SLOT_LOW: begin
                    if (sample_now) begin
                        rx_sh <= {io_s, rx_sh[7:1]};
                    end
                    // A write-0 slot stays low for the whole slot and skips SLOT_HIGH
                    if (tx_sh[0] && tick && (us_nxt == tim.low1)) begin
                        state  <= SLOT_HIGH;
                        IO_PD  <= 1'b0;
                        us_cnt <= 10'd0;
                    end else if (!tx_sh[0] && tick && (us_nxt == tim.slot)) begin
                        state  <= SLOT_REC;
                        IO_PD  <= 1'b0;
                        us_cnt <= 10'd0;
                    end
                end
                SLOT_HIGH: begin
                    if (sample_now) begin
                        rx_sh <= {io_s, rx_sh[7:1]};
                    end
                    if (tick && (slot_nxt == tim.slot)) begin
                        state  <= SLOT_REC;
                        us_cnt <= 10'd0;
                    end
                end
                SLOT_REC: begin
                    if (tick && (us_nxt == tim.rec)) begin
                        us_cnt <= 10'd0;
                        if (bit_cnt == 3'd7) begin
                            state   <= FIN;
                            DONE    <= 1'b1;
                            BUSY    <= 1'b0;
                            RX_DATA <= rx_sh;
                        end else begin
                            state    <= SLOT_LOW;
                            IO_PD    <= 1'b1;
                            bit_cnt  <= bit_cnt + 3'd1;
                            tx_sh    <= {1'b0, tx_sh[7:1]};
                            slot_cnt <= 10'd0;
                        end
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    us_cnt <= 10'd0;
                end
                default: begin
                    state <= IDLE;
                    IO_PD <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ow_master.sv
// Directed bench for ow_master with a behavioural 1-Wire slave on a pulled-up line.
`timescale 1ns/1ps
module tb_ow_master;

    logic       CLK = 1'b0;
    logic       MR = 1'b1;
    logic       CMD_RST = 1'b0;
    logic       CMD_BYTE = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       IO_IN;
    logic       IO_PD;
    logic       BUSY;
    logic       DONE;
    logic       PRESENCE;
    logic [7:0] RX_DATA;

    logic       slave_en = 1'b0;
    logic       slave_pd = 1'b0;
    logic [7:0] rom_byte = 8'h28;
    logic [2:0] slave_idx = 3'd0;
    realtime    t_fall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       presence;
        logic [7:0] rx;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   exp_w[$];

    // 100 ns clock: CLK_DIV=10 gives a 1 us tick
    always #50 CLK = ~CLK;

    assign IO_IN = ~(IO_PD | slave_pd);

    ow_master u_dut (
        .CLK      (CLK),
        .MR       (MR),
        .CMD_RST  (CMD_RST),
        .CMD_BYTE (CMD_BYTE),
        .TX_DATA  (TX_DATA),
`ifdef OW_OVERDRIVE_EN
        .OD       (1'b0),
`endif
        .IO_IN    (IO_IN),
        .IO_PD    (IO_PD),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PRESENCE (PRESENCE),
        .RX_DATA  (RX_DATA)
    );

    // Slave: answers slots with rom_byte LSB first, presence after a long low
    always begin
        @(negedge IO_IN);
        if (slave_en) begin
            t_fall = $realtime;
            if (!rom_byte[slave_idx]) begin
                slave_pd = 1'b1;
                #30000;
                slave_pd = 1'b0;
            end
            slave_idx = slave_idx + 3'd1;
            wait (IO_IN === 1'b1);
            if ($realtime - t_fall > 300000.0) begin
                slave_idx = 3'd0;
                #30000;
                slave_pd = 1'b1;
                #100000;
                slave_pd = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic pres, input logic [7:0] rx);
        exp_t e;
        for (int i = 0; i < 8; i++) exp_w.push_back(d[i] ? 60 : 600);
        e.presence = pres; e.rx = rx; e.lat = 5200;
        exp_q.push_back(e);
    endtask

    task automatic push_reset(input logic pres, input logic [7:0] rx);
        exp_t e;
        exp_w.push_back(4800);
        e.presence = pres; e.rx = rx; e.lat = 9600;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic r, input logic b, input logic [7:0] d);
        @(posedge CLK); #1;
        CMD_RST = r; CMD_BYTE = b; TX_DATA = d;
        @(posedge CLK); #1;
        CMD_RST = 1'b0; CMD_BYTE = 1'b0;
    endtask

    // Sample once per cycle, 1 ns after the edge; n counts cycles since accept
    task automatic run_seq(input int budget, input int inject_at);
        int n, w, dones, done_n;
        bit seen;
        exp_t e;
        n = 0; w = 0; dones = 0; done_n = 0; seen = 0;
        chk("busy_after_accept", BUSY, 1);
        while (n <= budget) begin
            CMD_BYTE = (n == inject_at);
            if (IO_PD === 1'b1) begin
                w++;
            end else if (w > 0) begin
                if (exp_w.size() == 0) chk("extra_pulse", w, 0);
                else chk("pulse_width", w, exp_w.pop_front());
                w = 0;
            end
            if (DONE === 1'b1) begin
                dones++;
                if (!seen) begin
                    seen = 1; done_n = n;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("presence", PRESENCE, e.presence);
                        chk("rx_data", RX_DATA, e.rx);
                        chk("done_latency_ok", (n >= e.lat) && (n <= e.lat + 4), 1);
                        chk("busy_at_done", BUSY, 0);
                    end
                end
            end
            if (seen && n >= done_n + 3) break;
            @(posedge CLK); #1;
            n++;
        end
        CMD_BYTE = 1'b0;
        chk("done_seen", seen, 1);
        chk("done_count", dones, 1);
        chk("missing_pulses", exp_w.size(), 0);
        chk("busy_after_done", BUSY, 0);
        exp_w.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_io_pd", IO_PD, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_presence", PRESENCE, 0);
        chk("rst_rx_data", RX_DATA, 8'h00);
        MR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset with slave present
        slave_en = 1'b1;
        push_reset(1'b1, 8'h00);
        issue(1'b1, 1'b0, 8'h00);
        run_seq(12000, -1);

        // Read slot: write 0xFF, slave returns 0x28
        push_byte(8'hFF, 1'b1, 8'h28);
        issue(1'b0, 1'b1, 8'hFF);
        run_seq(7000, -1);

        // Write 0xA5 to an idle bus; reads back the written bits
        slave_en = 1'b0;
        push_byte(8'hA5, 1'b1, 8'hA5);
        issue(1'b0, 1'b1, 8'hA5);
        run_seq(7000, -1);

        // Reset with no slave; RX_DATA must be left alone
        push_reset(1'b0, 8'hA5);
        issue(1'b1, 1'b0, 8'h00);
        run_seq(12000, -1);

        // Byte command while reset is in progress is ignored
        slave_en = 1'b1;
        push_reset(1'b1, 8'hA5);
        issue(1'b1, 1'b0, 8'h00);
        run_seq(12000, 200);

        // Simultaneous commands: reset wins
        slave_en = 1'b0;
        push_reset(1'b0, 8'hA5);
        issue(1'b1, 1'b1, 8'h00);
        run_seq(12000, -1);

        // Master reset in the middle of a low slot
        issue(1'b0, 1'b1, 8'h00);
        repeat (30) @(posedge CLK);
        #1;
        chk("slot_low_io_pd", IO_PD, 1);
        #20;
        MR = 1'b1;
        #1;
        chk("mr_io_pd", IO_PD, 0);
        chk("mr_busy", BUSY, 0);
        chk("mr_rx_data", RX_DATA, 8'h00);
        chk("mr_presence", PRESENCE, 0);
        @(posedge CLK); #1;
        MR = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        chk("post_mr_idle_io_pd", IO_PD, 0);
        chk("post_mr_idle_busy", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
